cgia_shifter: RTL and testbench
===============================

Name: cgia_shifter

Overview:
- Read side of the CGIA line buffers: consumes the 16-bit words the fetcher deposits and serializes them into a 1 bpp pixel stream.
- Owns the ping-pong buffer select. The shifter reads buffer lb_sel_o while the fetcher fills buffer ~lb_sel_o.
- Sits between the line-buffer RAM read port and the video DAC/output stage. Timed by the CRTC's HSYNC/VSYNC and horizontal active window.

Parameters:
- LINE_WORDS, 40: words displayed per scanline (640 px / 16); 1..63.
- ADR_W, 6: line-buffer word address width; 2^ADR_W > LINE_WORDS.

Ports:
- clk_i  in  1  Wishbone SYSCON clock; one pixel per cycle.
- reset_i  in  1  asynchronous, active-high reset.
- hsync_i  in  1  CRTC HSYNC, active high.
- vsync_i  in  1  CRTC VSYNC, active high.
- den_i  in  1  REGSET display enable.
- hactive_i  in  1  CRTC horizontal display window, active high.
- lb_sel_o  out  1  line buffer being read; the fetcher writes the other one.
- lb_adr_o  out  ADR_W  line-buffer read word address.
- lb_dat_i  in  16  line-buffer read data, valid one cycle after lb_adr_o (synchronous RAM).
- pixel_o  out  1  serialized pixel, registered.
- underrun_o  out  1  high for each cycle hactive_i&den_i is high while the shifter is not primed.

Behaviour:
- Reset (async, any state):
  - outputs: pixel_o=0, lb_sel_o=0, lb_adr_o=0, underrun_o=0.
  - internal: state=IDLE, shreg=0, hold=0, bitcnt=0, wcnt=0, hsync_q=0.
- HSYNC edge: hsync_i=1 & hsync_q=0, where hsync_q is the registered hsync_i.
  - lb_sel_o <= vsync_i ? 0 : ~lb_sel_o.
  - lb_adr_o<=0, bitcnt<=0, wcnt<=0, state<=PRIME0.
  - Takes priority over every other transition, including mid-line and mid-prime.
- States:
  - IDLE: waits for the HSYNC edge.
  - PRIME0: address 0 is on the bus. lb_adr_o<=1 -> PRIME1.
  - PRIME1: shreg<=lb_dat_i (word 0); lb_adr_o<=2; wcnt<=1 -> PRIME2.
  - PRIME2: hold<=lb_dat_i (word 1) -> READY.
  - Primed line: 3 cycles after the edge, shreg=word0, hold=word1, lb_adr_o=2.
- READY, when hactive_i&den_i:
  - pixel_o<=shreg[15]; shreg<=shreg<<1; bitcnt<=bitcnt+1 (4-bit wrap).
  - On bitcnt==15:
    - if wcnt<LINE_WORDS, shreg<=hold; otherwise shreg<=0 (border).
    - wcnt<=wcnt+1, saturating at LINE_WORDS.
    - set refill pending.
  - Cycle after refill pending: hold<=lb_dat_i (word at old lb_adr_o); lb_adr_o<=lb_adr_o+1, saturating at LINE_WORDS; clear pending.
- READY, when hactive_i&den_i is low: pixel_o<=0; shreg, bitcnt, wcnt and hold frozen. A pending refill still completes.
- IDLE/PRIMEx with hactive_i&den_i high: pixel_o<=0, underrun_o<=1. underrun_o is 0 in every other cycle.
- Pixel latency: one cycle from the enabled cycle to pixel_o. Pixels are MSB-first within each word.
- Past the line end: after LINE_WORDS words all further pixels are 0, and lb_adr_o stops advancing.
- den_i low for a whole line: pixels are 0 and priming still runs, so lb_sel_o keeps alternating.

Test Plan:
- Reset mid-shift: assert reset_i between clock edges -> all outputs 0 immediately, state IDLE. After release, no pixel activity until the next hsync edge.
- Buffer swap: edges with vsync_i=0, then 0, then 1 (starting from lb_sel_o=0) -> lb_sel_o = 1, 0, 0. Also check lb_adr_o = 0, 1, 2 over the 3 priming cycles.
- Serialize, LINE_WORDS=2:
  - buffer words $A5F0, $0001; hactive_i=den_i=1 for 40 cycles after priming.
  - pixel_o = 1010010111110000, then 0000000000000001, then 8 zeros.
  - lb_adr_o saturates at 2.
- Freeze: hactive_i low for 5 cycles in the middle of word $A5F0 after 4 pixels -> pixel_o=0 during the gap. Resumes with bits 0101 11110000, with no skip or repeat.
- Underrun: hactive_i=den_i=1 during PRIME0..PRIME2 -> underrun_o=1 for exactly 3 cycles, pixel_o=0. First real pixel appears the cycle after READY is reached.
- Restart: hsync edge after 20 pixels of a line -> wcnt/bitcnt reset, lb_sel_o toggles, lb_adr_o=0. New line starts from word 0 of the new buffer.

Source files
------------

// File: rtl/cgia_shifter.sv
// CGIA line-buffer read side: primes from the ping-pong line buffer on each HSYNC edge
// and serializes 16-bit words MSB-first into a 1 bpp pixel stream.
module cgia_shifter #(
    parameter int unsigned LINE_WORDS = 40,
    parameter int unsigned ADR_W      = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             den_i,
    input  logic             hactive_i,
    output logic             lb_sel_o,
    output logic [ADR_W-1:0] lb_adr_o,
    input  logic [15:0]      lb_dat_i,
    output logic             pixel_o,
    output logic             underrun_o
);

    typedef enum logic [2:0] {IDLE, PRIME0, PRIME1, PRIME2, READY} state_t;

    localparam logic [ADR_W-1:0] LW = ADR_W'(LINE_WORDS);

    state_t           state, state_d;
    logic [15:0]      shreg, shreg_d;
    logic [15:0]      hold, hold_d;
    logic [3:0]       bitcnt, bitcnt_d;
    logic [ADR_W-1:0] wcnt, wcnt_d;
    logic [ADR_W-1:0] adr_d;
    logic             sel_d;
    logic             pend, pend_d;
    logic             pix_d, und_d;
    logic             hsync_q;
    logic             en, hs_edge;

    assign en      = hactive_i & den_i;
    assign hs_edge = hsync_i & ~hsync_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d  = state;
        shreg_d  = shreg;
        hold_d   = hold;
        bitcnt_d = bitcnt;
        wcnt_d   = wcnt;
        adr_d    = lb_adr_o;
        sel_d    = lb_sel_o;
        pend_d   = pend;
        pix_d    = 1'b0;
        und_d    = (state != READY) & en;

        if (hs_edge) begin
            sel_d    = vsync_i ? 1'b0 : ~lb_sel_o;
            adr_d    = '0;
            bitcnt_d = '0;
            wcnt_d   = '0;
            pend_d   = 1'b0;
            state_d  = PRIME0;
        end else begin
            case (state)
                IDLE: ;
                PRIME0: begin
                    adr_d   = ADR_W'(1);
                    state_d = PRIME1;
                end
                PRIME1: begin
                    shreg_d = lb_dat_i;
                    adr_d   = ADR_W'(2);
                    wcnt_d  = ADR_W'(1);
                    state_d = PRIME2;
                end
                PRIME2: begin
                    hold_d  = lb_dat_i;
                    state_d = READY;
                end
                READY: begin
                    // Refill lands one cycle after the word boundary, even while the window is closed.
                    if (pend) begin
                        hold_d = lb_dat_i;
                        if (lb_adr_o < LW) adr_d = lb_adr_o + ADR_W'(1);
                        pend_d = 1'b0;
                    end
                    if (en) begin
                        pix_d    = shreg[15];
                        shreg_d  = {shreg[14:0], 1'b0};
                        bitcnt_d = bitcnt + 4'd1;
                        if (bitcnt == 4'hF) begin
                            shreg_d = (wcnt < LW) ? hold : '0;
                            if (wcnt < LW) wcnt_d = wcnt + ADR_W'(1);
                            pend_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shreg      <= '0;
            hold       <= '0;
            bitcnt     <= '0;
            wcnt       <= '0;
            lb_adr_o   <= '0;
            lb_sel_o   <= 1'b0;
            pend       <= 1'b0;
            pixel_o    <= 1'b0;
            underrun_o <= 1'b0;
            hsync_q    <= 1'b0;
        end else begin
            shreg      <= shreg_d;
            hold       <= hold_d;
            bitcnt     <= bitcnt_d;
            wcnt       <= wcnt_d;
            lb_adr_o   <= adr_d;
            lb_sel_o   <= sel_d;
            pend       <= pend_d;
            pixel_o    <= pix_d;
            underrun_o <= und_d;
            hsync_q    <= hsync_i;
        end
    end

endmodule

// File: tb/tb_cgia_shifter.sv
// Scoreboard bench for cgia_shifter with LINE_WORDS=2 and a behavioural
// synchronous line-buffer RAM.
module tb_cgia_shifter;

    localparam int unsigned LW = 2;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          hsync = 1'b0, vsync = 1'b0, den = 1'b0, hactive = 1'b0;
    logic          lb_sel;
    logic [AW-1:0] lb_adr;
    logic [15:0]   lb_dat;
    logic          pixel, underrun;

    logic [15:0] mem0 [64];
    logic [15:0] mem1 [64];

    typedef struct {
        logic pix;
        logic und;
        logic sel;
        int   st;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // model state: 0 idle, 1..3 priming, 4 ready
    int   m_state = 0;
    int   m_idx = 0;
    logic m_sel = 1'b0;
    logic m_hsq = 1'b0;

    cgia_shifter #(.LINE_WORDS(LW), .ADR_W(AW)) dut (
        .clk_i(clk), .reset_i(reset), .hsync_i(hsync), .vsync_i(vsync),
        .den_i(den), .hactive_i(hactive), .lb_sel_o(lb_sel), .lb_adr_o(lb_adr),
        .lb_dat_i(lb_dat), .pixel_o(pixel), .underrun_o(underrun)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) lb_dat <= lb_sel ? mem1[lb_adr] : mem0[lb_adr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic stream_bit(input int idx, input logic sel);
        logic [15:0] w;
        if (idx >= int'(LW) * 16) return 1'b0;
        w = sel ? mem1[idx / 16] : mem0[idx / 16];
        return w[15 - (idx % 16)];
    endfunction

    task automatic tick(input logic h, input logic d, input logic hs, input logic vs);
        exp_t e;
        logic en, hs_edge;
        @(negedge clk);
        hactive = h; den = d; hsync = hs; vsync = vs;
        en      = h & d;
        hs_edge = hs & ~m_hsq;
        e.pix = (m_state == 4 && en && !hs_edge) ? stream_bit(m_idx, m_sel) : 1'b0;
        e.und = (m_state != 4) && en;
        if (m_state == 4 && en && !hs_edge) m_idx++;
        if (hs_edge) begin
            m_sel   = vs ? 1'b0 : ~m_sel;
            m_state = 1;
            m_idx   = 0;
        end else if (m_state inside {1, 2, 3}) begin
            m_state++;
        end
        m_hsq = hs;
        e.sel = m_sel;
        e.st  = m_state;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pixel", 32'(pixel), 32'(e.pix));
        check("underrun", 32'(underrun), 32'(e.und));
        check("lb_sel", 32'(lb_sel), 32'(e.sel));
        if (e.st inside {1, 2, 3}) check("lb_adr_prime", 32'(lb_adr), 32'(e.st - 1));
    endtask

    task automatic hs_pulse(input logic vs, input logic en);
        tick(en, en, 1'b1, vs);
    endtask

    task automatic run(input int n, input logic h, input logic d);
        for (int i = 0; i < n; i++) tick(h, d, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem0[i] = 16'hFFFF;
            mem1[i] = 16'hFFFF;
        end
        mem0[0] = 16'h3C96; mem0[1] = 16'h8001;
        mem1[0] = 16'hA5F0; mem1[1] = 16'h0001;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_sel", 32'(lb_sel), 32'd0);
        check("rst_adr", 32'(lb_adr), 32'd0);
        check("rst_under", 32'(underrun), 32'd0);
        @(negedge clk) reset = 1'b0;
        run(2, 1'b0, 1'b0);

        // buffer swap: vsync 0, 0, 1 -> sel 1, 0, 0
        hs_pulse(1'b0, 1'b0); run(5, 1'b0, 1'b0);
        check("swap1", 32'(lb_sel), 32'd1);
        hs_pulse(1'b0, 1'b0); run(5, 1'b0, 1'b0);
        check("swap2", 32'(lb_sel), 32'd0);
        hs_pulse(1'b1, 1'b0); run(5, 1'b0, 1'b0);
        check("swap3", 32'(lb_sel), 32'd0);

        // serialize buffer 1 with underrun during priming
        hs_pulse(1'b0, 1'b0);
        run(43, 1'b1, 1'b1);
        check("adr_sat", 32'(lb_adr), 32'(LW));

        // freeze mid-word
        hs_pulse(1'b1, 1'b0); run(4, 1'b0, 1'b0);
        hs_pulse(1'b0, 1'b0); run(3, 1'b0, 1'b0);
        run(4, 1'b1, 1'b1);
        run(5, 1'b0, 1'b1);
        run(20, 1'b1, 1'b1);

        // restart mid-line from buffer 0 into buffer 1
        hs_pulse(1'b1, 1'b0); run(3, 1'b0, 1'b0);
        run(20, 1'b1, 1'b1);
        hs_pulse(1'b0, 1'b1);
        check("restart_sel", 32'(lb_sel), 32'd1);
        run(39, 1'b1, 1'b1);

        // reset mid-shift
        hs_pulse(1'b1, 1'b0); run(3, 1'b0, 1'b0);
        run(10, 1'b1, 1'b1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_pixel", 32'(pixel), 32'd0);
        check("mid_rst_sel", 32'(lb_sel), 32'd0);
        check("mid_rst_adr", 32'(lb_adr), 32'd0);
        check("mid_rst_under", 32'(underrun), 32'd0);
        hactive = 1'b0; den = 1'b0;
        @(negedge clk) reset = 1'b0;
        m_state = 0; m_idx = 0; m_sel = 1'b0; m_hsq = 1'b0;
        run(10, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
